regfile_writeback_queue: RTL and testbench

//  Write-back stage sitting directly upstream of the 32x32 register file; drives its DataIn/WrtAddress/Wenable.

---
 rtl/regfile_wb_pkg.sv | 15 +
 rtl/wb_match_unit.sv | 34 +++
 rtl/regfile_writeback_queue.sv | 124 ++++++++++++
 tb/tb_regfile_writeback_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and default sizes for the register-file write-back queue.
package regfile_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DEPTH  = 4;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match_unit.sv
// Associative lookup of one read address against the pending write-back entries;
// the youngest matching occupied entry supplies the data.
module wb_match_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
    input  logic [DEPTH-1:0]             i_occ,
    input  logic [PTR_W-1:0]             i_head,
    input  logic [ADDR_W-1:0]            i_query,
    output logic                         o_hit,
    output logic [DATA_W-1:0]            o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk from head (oldest) toward tail; later hits overwrite, so the youngest wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_occ[w_idx] && (i_addr[w_idx] == i_query) && (i_query != '0)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order write-back FIFO feeding the 32x32 register file, with RAW hazard flags.
// Define WB_BYPASS_EN to expose forwarded data (BypA_data/BypB_data) for pending writes.
module regfile_writeback_queue
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    flush,
    input  logic                    wb_hold,
    output logic [DATA_W-1:0]       DataIn,
    output logic [ADDR_W-1:0]       WrtAddress,
    output logic                    Wenable,
    input  logic [ADDR_W-1:0]       RdAddress1,
    input  logic [ADDR_W-1:0]       RdAddress2,
    output logic                    HazardA,
    output logic                    HazardB,
    output logic [$clog2(DEPTH):0]  count
`ifdef WB_BYPASS_EN
    ,
    output logic [DATA_W-1:0]       BypA_data,
    output logic [DATA_W-1:0]       BypB_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry fields are sized by the package; DATA_W/ADDR_W are expected to match it.
    wb_entry_t                   r_mem [DEPTH];
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [CNT_W-1:0]            r_count;

    logic                        w_push;
    logic                        w_wr;
    logic                        w_pop;
    logic                        w_nonempty;
    logic [DEPTH-1:0]            w_occ;
    logic [DEPTH-1:0][ADDR_W-1:0] w_addrs;
    logic [DEPTH-1:0][DATA_W-1:0] w_datas;
    logic [DATA_W-1:0]           w_byp_a;
    logic [DATA_W-1:0]           w_byp_b;

    assign w_nonempty = (r_count != '0);
    assign in_ready   = (r_count != CNT_W'(DEPTH)) & ~flush;
    assign w_push     = in_valid & in_ready;
    assign w_wr       = w_push & (in_addr != REG_ZERO);
    assign w_pop      = w_nonempty & ~wb_hold & ~flush;

    assign Wenable    = w_pop;
    assign count      = r_count;
    assign DataIn     = w_nonempty ? r_mem[r_rd_ptr].data : '0;
    assign WrtAddress = w_nonempty ? r_mem[r_rd_ptr].addr : '0;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy masks stale slots.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= '{addr: in_addr, data: in_data};
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PTR_W-1:0] w_age;
        assign w_age      = PTR_W'(i) - r_rd_ptr;
        assign w_occ[i]   = CNT_W'(w_age) < r_count;
        assign w_addrs[i] = r_mem[i].addr;
        assign w_datas[i] = r_mem[i].data;
    end

    wb_match_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_a (
        .i_addr  (w_addrs),
        .i_data  (w_datas),
        .i_occ   (w_occ),
        .i_head  (r_rd_ptr),
        .i_query (RdAddress1),
        .o_hit   (HazardA),
        .o_data  (w_byp_a)
    );

    wb_match_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_b (
        .i_addr  (w_addrs),
        .i_data  (w_datas),
        .i_occ   (w_occ),
        .i_head  (r_rd_ptr),
        .i_query (RdAddress2),
        .o_hit   (HazardB),
        .o_data  (w_byp_b)
    );

`ifdef WB_BYPASS_EN
    assign BypA_data = w_byp_a;
    assign BypB_data = w_byp_b;
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{w_byp_a, w_byp_b};
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: accepted pushes are queued, register-file writes pop and compare.
module tb_regfile_writeback_queue;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        flush = 1'b0;
    logic        wb_hold = 1'b0;
    logic [31:0] DataIn;
    logic [4:0]  WrtAddress;
    logic        Wenable;
    logic [4:0]  RdAddress1 = '0;
    logic [4:0]  RdAddress2 = '0;
    logic        HazardA;
    logic        HazardB;
    logic [2:0]  count;
`ifdef WB_BYPASS_EN
    logic [31:0] BypA_data;
    logic [31:0] BypB_data;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct { logic [4:0] a; logic [31:0] d; } exp_t;
    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] rf [32];

    regfile_writeback_queue dut (
        .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .flush(flush), .wb_hold(wb_hold),
        .DataIn(DataIn), .WrtAddress(WrtAddress), .Wenable(Wenable),
        .RdAddress1(RdAddress1), .RdAddress2(RdAddress2),
        .HazardA(HazardA), .HazardB(HazardB), .count(count)
`ifdef WB_BYPASS_EN
        , .BypA_data(BypA_data), .BypB_data(BypB_data)
`endif
    );

    always #5 clk = ~clk;

    // Register-file model: captures on the rising edge when Wenable is high.
    always @(posedge clk) begin
        if (Reset && Wenable) rf[WrtAddress] <= DataIn;
    end

    // Inputs change only just after the rising edge, so the falling edge sees what the next edge will do.
    always @(negedge clk) begin
        if (!Reset) begin
            sb.delete();
        end else begin
            if (Wenable) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_write got addr=%0d data=%h, required no write", WrtAddress, DataIn);
                end else begin
                    mon_e = sb.pop_front();
                    if (WrtAddress !== mon_e.a || DataIn !== mon_e.d) begin
                        errors++;
                        $display("FAIL sb_order got addr=%0d data=%h, required addr=%0d data=%h",
                                 WrtAddress, DataIn, mon_e.a, mon_e.d);
                    end
                end
            end
            if (in_valid && in_ready && in_addr != 5'd0) sb.push_back('{a: in_addr, d: in_data});
            if (flush) sb.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_addr = a; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (Wenable !== 1'b0 || count !== 3'd0 || DataIn !== 32'd0 || WrtAddress !== 5'd0 || HazardA !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got we=%b cnt=%0d din=%h wa=%0d hz=%b, required 0 0 0 0 0",
                     Wenable, count, DataIn, WrtAddress, HazardA);
        end
        tick();
        Reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", in_ready); end
        wb_hold = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push(5'(i + 1), 32'hA0 + i);
        RdAddress1 = 5'd2;
        #1;
        checks++;
        if (count !== 3'd3 || HazardA !== 1'b1) begin
            errors++; $display("FAIL burst_fill got cnt=%0d hz=%b required cnt=3 hz=1", count, HazardA);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (Wenable !== 1'b0 || count !== 3'd0 || HazardA !== 1'b0 || DataIn !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got we=%b cnt=%0d hz=%b din=%h required 0 0 0 0", Wenable, count, HazardA, DataIn);
        end
        tick();
        Reset = 1'b1; wb_hold = 1'b0; RdAddress1 = 5'd0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || count !== 3'd0 || Wenable !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy=%b cnt=%0d we=%b required 1 0 0", in_ready, count, Wenable);
        end
    endtask

    task automatic test_latency();
        tick();
        in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (Wenable !== 1'b0) begin errors++; $display("FAIL lat_same_cycle got we=%b required 0", Wenable); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (Wenable !== 1'b1 || WrtAddress !== 5'd5 || DataIn !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lat_next got we=%b wa=%0d din=%h required 1 5 deadbeef", Wenable, WrtAddress, DataIn);
        end
        tick();
        #1;
        checks++;
        if (rf[5] !== 32'hDEADBEEF || count !== 3'd0) begin
            errors++; $display("FAIL lat_rf got r5=%h cnt=%0d required deadbeef 0", rf[5], count);
        end
    endtask

    task automatic test_full();
        logic accepted;
        accepted = 1'b0;
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(8 + i), 32'h100 + i);
        in_valid = 1'b1; in_addr = 5'd20; in_data = 32'h55;
        #1;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_state got cnt=%0d rdy=%b required 4 0", count, in_ready);
        end
        tick();
        tick();
        #1;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_hold got cnt=%0d rdy=%b required 4 0", count, in_ready);
        end
        wb_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (Wenable !== 1'b1 || WrtAddress !== 5'(8 + k)) begin
                errors++; $display("FAIL full_drain%0d got we=%b wa=%0d required 1 %0d", k, Wenable, WrtAddress, 8 + k);
            end
            if (in_ready && in_valid) accepted = 1'b1;
            tick();
            if (accepted) in_valid = 1'b0;
        end
        #1;
        checks++;
        if (accepted !== 1'b1 || Wenable !== 1'b1 || WrtAddress !== 5'd20) begin
            errors++; $display("FAIL full_fifth got acc=%b we=%b wa=%0d required 1 1 20", accepted, Wenable, WrtAddress);
        end
        tick();
        #1;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL full_empty got cnt=%0d required 0", count); end
    endtask

    task automatic test_r0();
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h1234;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b required 1", in_ready); end
        tick();
        in_valid = 1'b0; RdAddress1 = 5'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (Wenable !== 1'b0 || count !== 3'd0 || HazardA !== 1'b0) begin
                errors++; $display("FAIL r0_drop got we=%b cnt=%0d hz=%b required 0 0 0", Wenable, count, HazardA);
            end
            tick();
        end
    endtask

    task automatic test_hazard();
        wb_hold = 1'b1;
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        RdAddress1 = 5'd7; RdAddress2 = 5'd3;
        #1;
        checks++;
        if (HazardA !== 1'b1 || HazardB !== 1'b0) begin
            errors++; $display("FAIL haz_flags got A=%b B=%b required 1 0", HazardA, HazardB);
        end
`ifdef WB_BYPASS_EN
        checks++;
        if (BypA_data !== 32'h22 || BypB_data !== 32'h0) begin
            errors++; $display("FAIL haz_byp got A=%h B=%h required 22 0", BypA_data, BypB_data);
        end
`endif
        RdAddress2 = 5'd7; wb_hold = 1'b0;
        #1;
        checks++;
        if (HazardB !== 1'b1 || HazardA !== 1'b1 || Wenable !== 1'b1) begin
            errors++; $display("FAIL haz_head got A=%b B=%b we=%b required 1 1 1", HazardA, HazardB, Wenable);
        end
        tick();
        #1;
        checks++;
        if (HazardA !== 1'b1 || count !== 3'd1) begin
            errors++; $display("FAIL haz_second got hz=%b cnt=%0d required 1 1", HazardA, count);
        end
        tick();
        #1;
        checks++;
        if (HazardA !== 1'b0 || HazardB !== 1'b0 || rf[7] !== 32'h22) begin
            errors++; $display("FAIL haz_clear got A=%b B=%b r7=%h required 0 0 22", HazardA, HazardB, rf[7]);
        end
        RdAddress1 = 5'd0; RdAddress2 = 5'd0;
    endtask

    task automatic test_flush();
        wb_hold = 1'b1;
        push(5'd9, 32'h9);
        push(5'd10, 32'hA);
        in_valid = 1'b1; in_addr = 5'd11; in_data = 32'hB; wb_hold = 1'b0;
        #1;
        checks++;
        if (Wenable !== 1'b1 || in_ready !== 1'b1 || count !== 3'd2) begin
            errors++; $display("FAIL simul_pre got we=%b rdy=%b cnt=%0d required 1 1 2", Wenable, in_ready, count);
        end
        tick();
        #1;
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL simul_count got %0d required 2", count); end
        in_addr = 5'd12; in_data = 32'hC; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || Wenable !== 1'b0) begin
            errors++; $display("FAIL flush_cycle got rdy=%b we=%b required 0 0", in_ready, Wenable);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (count !== 3'd0 || Wenable !== 1'b0 || rf[9] !== 32'h9) begin
                errors++; $display("FAIL flush_after got cnt=%0d we=%b r9=%h required 0 0 9", count, Wenable, rf[9]);
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_full();
        test_r0();
        test_hazard();
        test_flush();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d required 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
